// File: rtl/sanity_shared_ram.sv
// N-port shared single-array RAM: round-robin arbiter, byte-enabled writes, out-of-range
// error responses and a fixed-latency response pipeline. Optional: SANITY_SHARED_RAM_STALL_CNT_EN.
module sanity_shared_ram #(
  parameter int unsigned N_PORTS      = 2,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned NUM_WORDS    = 256,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic [N_PORTS-1:0]              req_i,
  output logic [N_PORTS-1:0]              gnt_o,
  output logic [N_PORTS-1:0]              rvalid_o,
  output logic [N_PORTS-1:0]              err_o,
  input  logic [N_PORTS*ADDR_WIDTH-1:0]   addr_i,
  input  logic [N_PORTS-1:0]              we_i,
  input  logic [N_PORTS*DATA_WIDTH/8-1:0] be_i,
  input  logic [N_PORTS*DATA_WIDTH-1:0]   wdata_i,
  output logic [N_PORTS*DATA_WIDTH-1:0]   rdata_o
`ifdef SANITY_SHARED_RAM_STALL_CNT_EN
  ,
  output logic [N_PORTS*16-1:0]           stall_cnt_o
`endif
);

  localparam int unsigned BE_W   = DATA_WIDTH / 8;
  localparam int unsigned IDX_W  = $clog2(NUM_WORDS);
  localparam int unsigned PORT_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
  localparam int unsigned HI_LSB = IDX_W + 2;

  typedef struct packed {
    logic                  valid;
    logic [PORT_W-1:0]     port;
    logic                  err;
    logic [DATA_WIDTH-1:0] rdata;
  } resp_t;

  logic [PORT_W-1:0]     ptr_q;
  logic                  gnt_any;
  logic [PORT_W-1:0]     gnt_idx;
  logic [N_PORTS-1:0]    gnt_vec;

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_we;
  logic [BE_W-1:0]       sel_be;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  oor;
  logic [IDX_W-1:0]      word_idx;
  logic                  addr_lsb_unused;

  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];
  resp_t                 resp_d;
  resp_t                 pipe_q [READ_LATENCY];
  resp_t                 resp_out;

  // Round-robin search: first pass covers ports at or above the pointer, second pass wraps.
  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    gnt_vec = '0;
    for (int j = 0; j < int'(N_PORTS); j++) begin
      if (!gnt_any && req_i[j] && (j >= int'(ptr_q))) begin
        gnt_any = 1'b1;
        gnt_idx = PORT_W'(j);
      end
    end
    for (int j = 0; j < int'(N_PORTS); j++) begin
      if (!gnt_any && req_i[j] && (j < int'(ptr_q))) begin
        gnt_any = 1'b1;
        gnt_idx = PORT_W'(j);
      end
    end
    if (gnt_any) gnt_vec[gnt_idx] = 1'b1;
  end

  assign gnt_o = gnt_vec;

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else if (gnt_any) begin
      ptr_q <= (gnt_idx == PORT_W'(N_PORTS - 1)) ? '0 : gnt_idx + PORT_W'(1);
    end
  end

  // One-hot AND-OR mux of the winning port's request fields.
  always_comb begin
    sel_addr  = '0;
    sel_we    = 1'b0;
    sel_be    = '0;
    sel_wdata = '0;
    for (int j = 0; j < int'(N_PORTS); j++) begin
      if (gnt_vec[j]) begin
        sel_addr  = addr_i[j*ADDR_WIDTH +: ADDR_WIDTH];
        sel_we    = we_i[j];
        sel_be    = be_i[j*BE_W +: BE_W];
        sel_wdata = wdata_i[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  generate
    if (ADDR_WIDTH > HI_LSB) begin : g_range_chk
      assign oor = |sel_addr[ADDR_WIDTH-1:HI_LSB];
    end else begin : g_no_range_chk
      assign oor = 1'b0;
    end
  endgenerate

  assign word_idx        = sel_addr[HI_LSB-1:2];
  assign addr_lsb_unused = ^sel_addr[1:0];

  // NOTE: the storage array has no reset; it survives rst_ni and maps onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (gnt_any && sel_we && !oor) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (sel_be[b]) mem[word_idx][b*8 +: 8] <= sel_wdata[b*8 +: 8];
      end
    end
  end

  // Writes and errored accesses answer with zero data; only in-range reads see the array.
  always_comb begin
    resp_d       = '0;
    resp_d.valid = gnt_any;
    resp_d.port  = gnt_idx;
    resp_d.err   = gnt_any && oor;
    if (gnt_any && !sel_we && !oor) resp_d.rdata = mem[word_idx];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < int'(READ_LATENCY); s++) pipe_q[s] <= '0;
    end else begin
      pipe_q[0] <= resp_d;
      for (int s = 1; s < int'(READ_LATENCY); s++) pipe_q[s] <= pipe_q[s-1];
    end
  end

  assign resp_out = pipe_q[READ_LATENCY-1];

  always_comb begin
    rvalid_o = '0;
    err_o    = '0;
    rdata_o  = '0;
    for (int p = 0; p < int'(N_PORTS); p++) begin
      if (resp_out.valid && (resp_out.port == PORT_W'(p))) begin
        rvalid_o[p]                         = 1'b1;
        err_o[p]                            = resp_out.err;
        rdata_o[p*DATA_WIDTH +: DATA_WIDTH] = resp_out.rdata;
      end
    end
  end

`ifdef SANITY_SHARED_RAM_STALL_CNT_EN
  logic [15:0] stall_cnt_q [N_PORTS];

  // Saturating count of cycles a port asks but loses arbitration.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int p = 0; p < int'(N_PORTS); p++) stall_cnt_q[p] <= '0;
    end else begin
      for (int p = 0; p < int'(N_PORTS); p++) begin
        if (req_i[p] && !gnt_vec[p] && (stall_cnt_q[p] != 16'hFFFF)) begin
          stall_cnt_q[p] <= stall_cnt_q[p] + 16'd1;
        end
      end
    end
  end

  always_comb begin
    stall_cnt_o = '0;
    for (int p = 0; p < int'(N_PORTS); p++) stall_cnt_o[p*16 +: 16] = stall_cnt_q[p];
  end
`endif

endmodule

// File: tb/tb_sanity_shared_ram.sv
// Directed self-checking bench for sanity_shared_ram: a READ_LATENCY=1 instance for
// arbitration/byte-enable/range tests and a READ_LATENCY=3 instance for pipelining and reset.
module tb_sanity_shared_ram;

  logic clk;
  logic rst_n;

  logic [1:0]  req_a, gnt_a, rvalid_a, err_a, we_a;
  logic [63:0] addr_a, wdata_a, rdata_a;
  logic [7:0]  be_a;

  logic [1:0]  req_b, gnt_b, rvalid_b, err_b, we_b;
  logic [63:0] addr_b, wdata_b, rdata_b;
  logic [7:0]  be_b;

`ifdef SANITY_SHARED_RAM_STALL_CNT_EN
  logic [31:0] stall_a, stall_b;
`endif

  int n_checks = 0;
  int n_errors = 0;

  sanity_shared_ram #(.N_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_WORDS(256),
                      .READ_LATENCY(1)) u_dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_a), .gnt_o(gnt_a), .rvalid_o(rvalid_a),
    .err_o(err_a), .addr_i(addr_a), .we_i(we_a), .be_i(be_a), .wdata_i(wdata_a),
    .rdata_o(rdata_a)
`ifdef SANITY_SHARED_RAM_STALL_CNT_EN
    , .stall_cnt_o(stall_a)
`endif
  );

  sanity_shared_ram #(.N_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_WORDS(256),
                      .READ_LATENCY(3)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_b), .gnt_o(gnt_b), .rvalid_o(rvalid_b),
    .err_o(err_b), .addr_i(addr_b), .we_i(we_b), .be_i(be_b), .wdata_i(wdata_b),
    .rdata_o(rdata_b)
`ifdef SANITY_SHARED_RAM_STALL_CNT_EN
    , .stall_cnt_o(stall_b)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction on instance A: grant checked same cycle, response next cycle.
  task automatic single_a(input int port, input logic we, input logic [31:0] addr,
                          input logic [3:0] be, input logic [31:0] wdata,
                          input logic exp_err, input logic [31:0] exp_rdata, input string tag);
    logic [1:0]  ev;
    logic [63:0] er;
    ev = '0;
    ev[port] = 1'b1;
    er = '0;
    er[port*32 +: 32] = exp_rdata;
    req_a = '0;
    req_a[port] = 1'b1;
    we_a[port] = we;
    addr_a[port*32 +: 32] = addr;
    be_a[port*4 +: 4] = be;
    wdata_a[port*32 +: 32] = wdata;
    #1;
    check({tag, "_gnt"}, 64'(gnt_a), 64'(ev));
    tick();
    req_a = '0;
    we_a = '0;
    check({tag, "_rvalid"}, 64'(rvalid_a), 64'(ev));
    check({tag, "_err"}, 64'(err_a), exp_err ? 64'(ev) : 64'd0);
    check({tag, "_rdata"}, rdata_a, er);
  endtask

  initial begin
    rst_n = 1'b0;
    req_a = '0; we_a = '0; addr_a = '0; be_a = '0; wdata_a = '0;
    req_b = '0; we_b = '0; addr_b = '0; be_b = '0; wdata_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 64'(gnt_a), 64'd0);
    check("rst_rvalid", 64'(rvalid_a), 64'd0);
    check("rst_err", 64'(err_a), 64'd0);
    check("rst_rdata", rdata_a, 64'd0);
    check("rst_rvalid_b", 64'(rvalid_b), 64'd0);
    rst_n = 1'b1;
    tick();

    // Both ports hammer with be=0 writes: grants alternate starting at port 0.
    for (int c = 0; c < 6; c++) begin
      req_a = 2'b11; we_a = 2'b11; be_a = '0; addr_a = '0;
      #1;
      check($sformatf("rr_gnt_%0d", c), 64'(gnt_a), (c % 2 == 0) ? 64'd1 : 64'd2);
      if (c > 0) check($sformatf("rr_rvalid_%0d", c), 64'(rvalid_a),
                       (c % 2 == 1) ? 64'd1 : 64'd2);
      tick();
    end
    req_a = '0; we_a = '0;
    check("rr_rvalid_last", 64'(rvalid_a), 64'd2);
    check("rr_rdata_zero", rdata_a, 64'd0);
`ifdef SANITY_SHARED_RAM_STALL_CNT_EN
    check("stall_cnt", 64'(stall_a), {32'd0, 16'd3, 16'd3});
`endif
    tick();
    check("rr_idle", 64'(rvalid_a), 64'd0);

    // Basic write then read on port 0.
    single_a(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0, "wr10");
    single_a(0, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0, 32'hDEADBEEF, "rd10");

    // Byte enables on word 4, from port 1.
    single_a(1, 1'b1, 32'h10, 4'hF, 32'h0, 1'b0, 32'h0, "clr4");
    single_a(1, 1'b1, 32'h10, 4'b0101, 32'h11223344, 1'b0, 32'h0, "be_wr");
    single_a(1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0, 32'h00220044, "be_rd");
    single_a(0, 1'b0, 32'h13, 4'h0, 32'h0, 1'b0, 32'h00220044, "lsb_ignored");

    // Out-of-range: error, zero data, no aliasing write into word 0.
    single_a(0, 1'b1, 32'h0, 4'hF, 32'hA5A5A5A5, 1'b0, 32'h0, "wr0");
    single_a(0, 1'b0, 32'h400, 4'h0, 32'h0, 1'b1, 32'h0, "oor_rd");
    single_a(1, 1'b1, 32'h400, 4'hF, 32'hFFFFFFFF, 1'b1, 32'h0, "oor_wr");
    single_a(0, 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 32'hA5A5A5A5, "rd0_after_oor");
    single_a(1, 1'b1, 32'h3FC, 4'hF, 32'h5555AAAA, 1'b0, 32'h0, "wr_top");
    single_a(1, 1'b0, 32'h3FC, 4'h0, 32'h0, 1'b0, 32'h5555AAAA, "rd_top");

    // Instance B: preload words 0..2 back-to-back from port 0.
    for (int w = 0; w < 3; w++) begin
      req_b = 2'b01; we_b = 2'b01; be_b = 8'h0F;
      addr_b = {32'h0, 32'(4 * w)};
      wdata_b = {32'h0, 32'((w + 1) * 256)};
      #1;
      check($sformatf("pre_gnt_%0d", w), 64'(gnt_b), 64'd1);
      tick();
    end
    req_b = '0; we_b = '0;
    repeat (4) tick();

    // Port 1 pipelined reads: rvalid on cycles 3,4,5 after the first grant.
    for (int c = 0; c < 7; c++) begin
      if (c < 3) begin
        req_b = 2'b10; we_b = '0; addr_b = {32'(4 * c), 32'h0};
      end else begin
        req_b = '0;
      end
      #1;
      check($sformatf("pipe_gnt_%0d", c), 64'(gnt_b), (c < 3) ? 64'd2 : 64'd0);
      check($sformatf("pipe_rvalid_%0d", c), 64'(rvalid_b),
            (c >= 3 && c <= 5) ? 64'd2 : 64'd0);
      if (c >= 3 && c <= 5)
        check($sformatf("pipe_rdata_%0d", c), rdata_b, {32'((c - 2) * 256), 32'h0});
      tick();
    end

    // Reset one cycle after a grant to port 0: response dropped, pointer back to 0.
    req_b = 2'b01; we_b = '0; addr_b = {32'h0, 32'h4};
    #1;
    check("rst_pre_gnt", 64'(gnt_b), 64'd1);
    tick();
    req_b = '0;
    rst_n = 1'b0;
    #1;
    check("rst_mid_rvalid", 64'(rvalid_b), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("rst_drop_%0d", c), 64'(rvalid_b), 64'd0);
      tick();
    end
    req_b = 2'b11; we_b = '0; addr_b = {32'h8, 32'h8};
    #1;
    check("rst_ptr_gnt", 64'(gnt_b), 64'd1);
    tick();
    req_b = '0;
    tick();
    tick();
    check("rst_keep_rvalid", 64'(rvalid_b), 64'd1);
    check("rst_keep_rdata", rdata_b, 64'h300);
    single_a(1, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0, 32'h00220044, "rst_keep_a");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
